cache_ctrl_16: RTL and testbench
================================

# cache_ctrl_16

Miss-handling controller for the 16-word direct-mapped data cache in pipeline step 4. It watches the step-4 access (tag/index/offset, hit) and drives the cache control inputs: is_load_bus, control_tag, control_index, control_offset and control_data_mux. On a load miss it stalls the pipeline, waits a programmable memory latency, then refills the 4-word line one word per cycle. It also performs write-through store-hit updates and keeps hit/miss counters.

## Interface
- CACHE_SIZE, 16, cache words (4 lines x 4 words)
- LINE_WORDS, 4, words per line
- MISS_LATENCY, 2, wait cycles before refill (0..15)
- CNT_W, 16, counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mem_req  in  1  valid load/store access in step 4
- mem_we  in  1  1 = store, 0 = load
- tag  in  1  address bit 4
- index  in  2  address bits 3:2
- offset  in  2  address bits 1:0
- hit  in  1  cache hit for the current tag/index
- stall  out  1  freeze steps 1-4
- is_load_bus  out  4  one-hot line write enable
- control_tag  out  1  tag written and memory half selected (1 = words 16-31)
- control_index  out  2  line being written
- control_offset  out  4  one-hot word enable within the line
- control_data_mux  out  16  per-word source; bit k = cache word index*4+offset; 1 = store data (rdata2), 0 = memory
- hit_count  out  CNT_W  saturating hit counter
- miss_count  out  CNT_W  saturating miss counter

## Operation
- States: IDLE, WAIT, FILL. Registers: state, wait counter (4 b), fill word counter (2 b), captured tag/index, replay flag, both counters.
- IDLE, no mem_req: all control outputs 0, stall 0.
- IDLE, load hit: no cache write, stall 0.
- IDLE, load miss (mem_req & ~mem_we & ~hit): stall 1 combinationally in the same cycle. Capture tag/index. Go to WAIT if MISS_LATENCY > 0, otherwise go to FILL.
- WAIT: stall 1, all write enables 0. Count MISS_LATENCY cycles, then go to FILL with word counter 0.
- FILL word w: stall 1; is_load_bus = onehot(captured index); control_offset = onehot(w); control_data_mux = 0; control_tag/control_index = captured values. After w = 3, go to IDLE and set replay.
- IDLE after FILL: the held access now hits; stall 0; replay cleared.
- Store hit (IDLE, mem_req & mem_we & hit): is_load_bus = onehot(index), control_offset = onehot(offset), control_data_mux bit index*4+offset = 1, control_tag = tag. No stall. Memory is written by the pipeline's own is_write_mem (write-through).
- Store miss: no cache write, no stall, no allocate.
- Counters count only in IDLE with mem_req. hit increments hit_count; miss increments miss_count. The replay cycle does not increment either counter. Both counters saturate at all-ones.
- Outside IDLE, mem_req, mem_we, tag, index, offset and hit are ignored; the pipeline holds them stable under stall.

## Timing
- Reset (rst = 0, asynchronous): state IDLE, counters 0, replay 0. All outputs 0 (stall 0; combinational outputs follow IDLE rules once rst = 1).
- Load miss stall length: 1 + MISS_LATENCY + 4 cycles (7 at default). stall drops in the replay cycle.
- Store hit write and load hit: zero added latency.
- Reset mid-WAIT/FILL: abort immediately to IDLE. The cache shares rst, so a partially filled line is invalidated.
- Back-to-back miss in the replay cycle cannot occur (replay hits). A new miss in the cycle after replay starts a fresh refill.
- Count saturation: at 2^CNT_W-1, further events leave the count unchanged.

## Test plan
- Reset with rst = 0 mid-FILL (word 2) -> state IDLE, stall 0, counters 0, is_load_bus 0 asynchronously.
- Load miss tag = 1, index = 2, MISS_LATENCY = 2 -> stall high 7 cycles. FILL cycles show is_load_bus = 0100, control_index = 2, control_tag = 1, control_offset 0001, 0010, 0100, 1000. Replay cycle stall 0; miss_count = 1, hit_count = 0.
- MISS_LATENCY = 0 load miss -> FILL starts the next cycle; stall high exactly 5 cycles.
- Store hit index = 1, offset = 3 -> same cycle control_data_mux = 0x0080, is_load_bus = 0010, control_offset = 1000, stall 0, hit_count + 1.
- Store miss -> all enables 0, stall 0, miss_count + 1, no state change.
- Preload hit_count to max via 2^CNT_W hits (CNT_W = 4 build) -> count holds at 15.

Source files
------------

// File: rtl/cache_ctrl_16.sv
// Miss-handling controller for the 16-word direct-mapped step-4 data cache.
// Load miss: stall, wait MISS_LATENCY cycles, refill the line one word per cycle, then replay.
// Store hit: same-cycle write-through word update. Also keeps saturating hit and miss counters.
// Ports:
//   clk_i, rst_ni                  clock (rising edge), asynchronous active-low reset
//   mem_req_i, mem_we_i            step-4 access valid, 1 = store / 0 = load
//   tag_i, index_i, offset_i       access address fields (bit 4, bits 3:2, bits 1:0)
//   hit_i                          cache hit for the current tag/index
//   stall_o                        freeze pipeline steps 1-4
//   is_load_bus_o                  one-hot line write enable
//   control_tag_o/control_index_o  tag and line being written
//   control_offset_o               one-hot word enable within the line
//   control_data_mux_o             per-word source, 1 = store data, 0 = memory
//   hit_count_o, miss_count_o      saturating event counters
module cache_ctrl_16 #(
  parameter int CACHE_SIZE   = 16,
  parameter int LINE_WORDS   = 4,
  parameter int MISS_LATENCY = 2,
  parameter int CNT_W        = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  mem_req_i,
  input  logic                                  mem_we_i,
  input  logic                                  tag_i,
  input  logic [$clog2(CACHE_SIZE/LINE_WORDS)-1:0] index_i,
  input  logic [$clog2(LINE_WORDS)-1:0]         offset_i,
  input  logic                                  hit_i,
  output logic                                  stall_o,
  output logic [CACHE_SIZE/LINE_WORDS-1:0]      is_load_bus_o,
  output logic                                  control_tag_o,
  output logic [$clog2(CACHE_SIZE/LINE_WORDS)-1:0] control_index_o,
  output logic [LINE_WORDS-1:0]                 control_offset_o,
  output logic [CACHE_SIZE-1:0]                 control_data_mux_o,
  output logic [CNT_W-1:0]                      hit_count_o,
  output logic [CNT_W-1:0]                      miss_count_o
);

  localparam int LINES = CACHE_SIZE / LINE_WORDS;
  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam logic [3:0]       WAIT_LAST = 4'((MISS_LATENCY > 0) ? MISS_LATENCY - 1 : 0);
  localparam logic [OFF_W-1:0] WORD_LAST = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FILL} state_t;

  state_t           state_q;
  logic [3:0]       wait_q;
  logic [OFF_W-1:0] word_q;
  logic             tag_q;
  logic [IDX_W-1:0] idx_q;
  logic             replay_q;
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  logic load_miss;
  assign load_miss = mem_req_i & ~mem_we_i & ~hit_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      word_q     <= '0;
      tag_q      <= 1'b0;
      idx_q      <= '0;
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          replay_q <= 1'b0;
          // The replayed access after a refill is the same access already
          // counted as a miss, so it must not be counted again.
          if (mem_req_i && !replay_q) begin
            if (hit_i) begin
              if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
            end else begin
              if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            end
          end
          if (load_miss) begin
            tag_q   <= tag_i;
            idx_q   <= index_i;
            wait_q  <= '0;
            word_q  <= '0;
            state_q <= (MISS_LATENCY == 0) ? S_FILL : S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            word_q  <= '0;
            state_q <= S_FILL;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_FILL: begin
          word_q <= word_q + 1'b1;
          if (word_q == WORD_LAST) begin
            replay_q <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stall and store-hit enables must act in the access cycle itself, so the
  // control outputs are decoded from state plus live inputs. They are forced
  // low while reset is asserted even though the pipeline inputs may be held.
  always_comb begin
    stall_o            = 1'b0;
    is_load_bus_o      = '0;
    control_tag_o      = 1'b0;
    control_index_o    = '0;
    control_offset_o   = '0;
    control_data_mux_o = '0;
    if (rst_ni) begin
      case (state_q)
        S_IDLE: begin
          if (load_miss) begin
            stall_o = 1'b1;
          end else if (mem_req_i && mem_we_i && hit_i) begin
            is_load_bus_o[index_i]                = 1'b1;
            control_offset_o[offset_i]            = 1'b1;
            control_data_mux_o[{index_i, offset_i}] = 1'b1;
            control_tag_o                         = tag_i;
            control_index_o                       = index_i;
          end
        end
        S_WAIT: stall_o = 1'b1;
        S_FILL: begin
          stall_o                  = 1'b1;
          is_load_bus_o[idx_q]     = 1'b1;
          control_offset_o[word_q] = 1'b1;
          control_tag_o            = tag_q;
          control_index_o          = idx_q;
        end
        default: stall_o = 1'b0;
      endcase
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl_16.sv
module tb_cache_ctrl_16;

  logic clk = 1'b0;
  logic rst_n;
  logic req, we, tg, hit;
  logic [1:0] idx, off;

  logic        st[3];
  logic [3:0]  lb[3];
  logic        ctag[3];
  logic [1:0]  cidx[3];
  logic [3:0]  coff[3];
  logic [15:0] dmux[3];
  logic [15:0] hc0, mc0, hc1, mc1;
  logic [3:0]  hc2, mc2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // u0: default build, u1: zero miss latency, u2: 4-bit counters
  cache_ctrl_16 u0 (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req), .mem_we_i(we), .tag_i(tg),
    .index_i(idx), .offset_i(off), .hit_i(hit), .stall_o(st[0]), .is_load_bus_o(lb[0]),
    .control_tag_o(ctag[0]), .control_index_o(cidx[0]), .control_offset_o(coff[0]),
    .control_data_mux_o(dmux[0]), .hit_count_o(hc0), .miss_count_o(mc0));

  cache_ctrl_16 #(.MISS_LATENCY(0)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req), .mem_we_i(we), .tag_i(tg),
    .index_i(idx), .offset_i(off), .hit_i(hit), .stall_o(st[1]), .is_load_bus_o(lb[1]),
    .control_tag_o(ctag[1]), .control_index_o(cidx[1]), .control_offset_o(coff[1]),
    .control_data_mux_o(dmux[1]), .hit_count_o(hc1), .miss_count_o(mc1));

  cache_ctrl_16 #(.CNT_W(4)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req), .mem_we_i(we), .tag_i(tg),
    .index_i(idx), .offset_i(off), .hit_i(hit), .stall_o(st[2]), .is_load_bus_o(lb[2]),
    .control_tag_o(ctag[2]), .control_index_o(cidx[2]), .control_offset_o(coff[2]),
    .control_data_mux_o(dmux[2]), .hit_count_o(hc2), .miss_count_o(mc2));

  task automatic set_in(input logic r, input logic w, input logic t, input logic [1:0] i,
                        input logic [1:0] o, input logic h);
    req = r; we = w; tg = t; idx = i; off = o; hit = h;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_in(0, 0, 0, 2'd0, 2'd0, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 2'd0, 2'd0, 0);
    #2;
    n_cmp++; if (st[0] !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", st[0]); end
    n_cmp++; if (lb[0] !== 4'b0) begin n_err++; $display("FAIL reset_lb got=%b exp=0000", lb[0]); end
    n_cmp++; if (hc0 !== 16'd0 || mc0 !== 16'd0) begin n_err++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", hc0, mc0); end
    do_reset();
    // start a miss, run into FILL word 2, then pull reset mid-cycle
    set_in(1, 0, 1, 2'd2, 2'd0, 0);
    repeat (5) @(negedge clk);
    #1;
    n_cmp++; if (coff[0] !== 4'b0100 || st[0] !== 1'b1) begin n_err++; $display("FAIL pre_reset_fill2 got off=%b stall=%b exp off=0100 stall=1", coff[0], st[0]); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (st[0] !== 1'b0) begin n_err++; $display("FAIL midfill_reset_stall got=%b exp=0", st[0]); end
    n_cmp++; if (lb[0] !== 4'b0) begin n_err++; $display("FAIL midfill_reset_lb got=%b exp=0000", lb[0]); end
    n_cmp++; if (mc0 !== 16'd0 || hc0 !== 16'd0) begin n_err++; $display("FAIL midfill_reset_cnt got=%0d/%0d exp=0/0", hc0, mc0); end
    @(negedge clk);
    set_in(0, 0, 0, 2'd0, 2'd0, 0);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (st[0] !== 1'b0 || lb[0] !== 4'b0) begin n_err++; $display("FAIL post_reset_idle got stall=%b lb=%b exp 0/0000", st[0], lb[0]); end
  endtask

  task automatic test_load_miss();
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 0) set_in(1, 0, 1, 2'd2, 2'd1, 0);
      if (k == 7) hit = 1'b1;
      if (k == 8) set_in(0, 0, 0, 2'd0, 2'd0, 0);
      #1;
      n_cmp++;
      if (st[0] !== (k < 7)) begin n_err++; $display("FAIL miss_stall k=%0d got=%b exp=%b", k, st[0], (k < 7)); end
      if (k >= 3 && k <= 6) begin
        n_cmp++;
        if (lb[0] !== 4'b0100 || cidx[0] !== 2'd2 || ctag[0] !== 1'b1 || coff[0] !== 4'(1 << (k - 3)) || dmux[0] !== 16'h0)
          begin n_err++; $display("FAIL miss_fill k=%0d got lb=%b idx=%0d tag=%b off=%b mux=%h exp lb=0100 idx=2 tag=1 off=%b mux=0000",
                                  k, lb[0], cidx[0], ctag[0], coff[0], dmux[0], 4'(1 << (k - 3))); end
      end else begin
        n_cmp++;
        if (lb[0] !== 4'b0 || coff[0] !== 4'b0) begin n_err++; $display("FAIL miss_noen k=%0d got lb=%b off=%b exp 0", k, lb[0], coff[0]); end
      end
      if (k >= 7) begin
        n_cmp++;
        if (mc0 !== 16'd1 || hc0 !== 16'd0) begin n_err++; $display("FAIL miss_counts k=%0d got hit=%0d miss=%0d exp 0/1", k, hc0, mc0); end
      end
    end
  endtask

  task automatic test_zero_latency();
    do_reset();
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k == 0) set_in(1, 0, 0, 2'd3, 2'd0, 0);
      if (k == 5) hit = 1'b1;
      if (k == 6) set_in(0, 0, 0, 2'd0, 2'd0, 0);
      #1;
      n_cmp++;
      if (st[1] !== (k < 5)) begin n_err++; $display("FAIL lat0_stall k=%0d got=%b exp=%b", k, st[1], (k < 5)); end
      if (k >= 1 && k <= 4) begin
        n_cmp++;
        if (lb[1] !== 4'b1000 || coff[1] !== 4'(1 << (k - 1)))
          begin n_err++; $display("FAIL lat0_fill k=%0d got lb=%b off=%b exp lb=1000 off=%b", k, lb[1], coff[1], 4'(1 << (k - 1))); end
      end
    end
    n_cmp++; if (mc1 !== 16'd1 || hc1 !== 16'd0) begin n_err++; $display("FAIL lat0_counts got hit=%0d miss=%0d exp 0/1", hc1, mc1); end
  endtask

  task automatic test_store_hit();
    do_reset();
    @(negedge clk);
    set_in(1, 1, 1, 2'd1, 2'd3, 1);
    #1;
    n_cmp++; if (dmux[0] !== 16'h0080) begin n_err++; $display("FAIL sthit_mux got=%h exp=0080", dmux[0]); end
    n_cmp++; if (lb[0] !== 4'b0010 || coff[0] !== 4'b1000) begin n_err++; $display("FAIL sthit_en got lb=%b off=%b exp 0010/1000", lb[0], coff[0]); end
    n_cmp++; if (st[0] !== 1'b0 || ctag[0] !== 1'b1) begin n_err++; $display("FAIL sthit_stall_tag got stall=%b tag=%b exp 0/1", st[0], ctag[0]); end
    @(negedge clk);
    set_in(0, 0, 0, 2'd0, 2'd0, 0);
    #1;
    n_cmp++; if (hc0 !== 16'd1 || mc0 !== 16'd0) begin n_err++; $display("FAIL sthit_count got hit=%0d miss=%0d exp 1/0", hc0, mc0); end
  endtask

  task automatic test_store_miss();
    do_reset();
    @(negedge clk);
    set_in(1, 1, 0, 2'd2, 2'd1, 0);
    #1;
    n_cmp++; if (lb[0] !== 4'b0 || coff[0] !== 4'b0 || dmux[0] !== 16'h0 || st[0] !== 1'b0)
      begin n_err++; $display("FAIL stmiss_en got lb=%b off=%b mux=%h stall=%b exp all 0", lb[0], coff[0], dmux[0], st[0]); end
    @(negedge clk);
    set_in(1, 0, 0, 2'd2, 2'd1, 1);
    #1;
    n_cmp++; if (mc0 !== 16'd1 || hc0 !== 16'd0 || st[0] !== 1'b0)
      begin n_err++; $display("FAIL stmiss_after got miss=%0d hit=%0d stall=%b exp 1/0/0", mc0, hc0, st[0]); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      set_in(1, 0, 0, 2'(k), 2'(k), 1);
      if (k == 15) begin
        #1;
        n_cmp++; if (hc2 !== 4'd15) begin n_err++; $display("FAIL sat_reach got=%0d exp=15", hc2); end
      end
    end
    @(negedge clk);
    set_in(0, 0, 0, 2'd0, 2'd0, 0);
    #1;
    n_cmp++; if (hc2 !== 4'd15 || mc2 !== 4'd0) begin n_err++; $display("FAIL sat_hold got hit=%0d miss=%0d exp 15/0", hc2, mc2); end
  endtask

  // Reference model: after a load miss the controller is busy for lat+4
  // further cycles (lat waits, then words 0..3 of the captured line), after
  // which one replay cycle is not counted.
  task automatic test_random(input int d);
    int lat, rem, mh, mm;
    bit replay;
    logic cap_t;
    logic [1:0] cap_i;
    logic e_st, e_tag;
    logic [3:0] e_lb, e_off;
    logic [1:0] e_idx;
    logic [15:0] e_dm, dh, dm;
    lat = (d == 0) ? 2 : 0;
    rem = 0; mh = 0; mm = 0; replay = 0; cap_t = 0; cap_i = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (replay) hit = 1'b1;
      else if (rem == 0)
        set_in(($urandom % 4) != 0, $urandom % 2, $urandom % 2, 2'($urandom % 4), 2'($urandom % 4), $urandom % 2);
      e_st = 0; e_lb = 0; e_off = 0; e_dm = 0; e_tag = 0; e_idx = 0;
      if (rem > 0) begin
        e_st = 1;
        if ((lat + 4 - rem) >= lat) begin
          e_lb = 4'(1 << cap_i); e_off = 4'(1 << (lat + 4 - rem - lat));
          e_tag = cap_t; e_idx = cap_i;
        end
      end else if (req && !we && !hit) begin
        e_st = 1;
      end else if (req && we && hit) begin
        e_lb = 4'(1 << idx); e_off = 4'(1 << off); e_dm = 16'(1 << (idx * 4 + off));
        e_tag = tg; e_idx = idx;
      end
      #1;
      dh = (d == 0) ? hc0 : hc1;
      dm = (d == 0) ? mc0 : mc1;
      n_cmp++;
      if (st[d] !== e_st || lb[d] !== e_lb || coff[d] !== e_off || dmux[d] !== e_dm ||
          (e_lb != 0 && (ctag[d] !== e_tag || cidx[d] !== e_idx)) || dh !== 16'(mh) || dm !== 16'(mm))
        begin n_err++; $display("FAIL rand_d%0d c=%0d got st=%b lb=%b off=%b mux=%h tag=%b idx=%0d h=%0d m=%0d exp st=%b lb=%b off=%b mux=%h tag=%b idx=%0d h=%0d m=%0d",
          d, c, st[d], lb[d], coff[d], dmux[d], ctag[d], cidx[d], dh, dm, e_st, e_lb, e_off, e_dm, e_tag, e_idx, mh, mm); end
      // advance the model across the clock edge
      if (rem > 0) begin
        rem--;
        if (rem == 0) replay = 1;
      end else begin
        if (req && !replay) begin
          if (hit) mh++; else mm++;
        end
        replay = 0;
        if (req && !we && !hit) begin
          rem = lat + 4; cap_t = tg; cap_i = idx;
        end
      end
    end
  endtask

  initial begin
    set_in(0, 0, 0, 2'd0, 2'd0, 0);
    test_reset();
    test_load_miss();
    test_zero_latency();
    test_store_hit();
    test_store_miss();
    test_saturation();
    test_random(0);
    test_random(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
